// File: rtl/traffic_light_intersection.sv
// rtl/traffic_light_intersection.sv - two-approach intersection controller with pedestrian crossing
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   mode[1:0]    00 auto, 01 manual (btn-stepped), 1x flashing night mode
//   btn          manual-advance button (synchronised level, rising edge used)
//   ped_req      pedestrian request (level or pulse), latched until served
//   ns_r/g/b     NS lamp colour channels, LED_W bits each
//   ew_r/g/b     EW lamp colour channels, LED_W bits each
//   ped_walk     walk signal
//   ped_pending  latched pedestrian request not yet served
//   phase[2:0]   current state code (debug)
module traffic_light_intersection #(
    parameter int TICK_DIV   = 10,
    parameter int GREEN_SEC  = 5,
    parameter int YELLOW_SEC = 2,
    parameter int ALLRED_SEC = 1,
    parameter int PED_SEC    = 4,
    parameter int LED_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             btn,
    input  logic             ped_req,
    output logic [LED_W-1:0] ns_r,
    output logic [LED_W-1:0] ns_g,
    output logic [LED_W-1:0] ns_b,
    output logic [LED_W-1:0] ew_r,
    output logic [LED_W-1:0] ew_g,
    output logic [LED_W-1:0] ew_b,
    output logic             ped_walk,
    output logic             ped_pending,
    output logic [2:0]       phase
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_B = 3'd5,
        PED_WALK  = 3'd6,
        FLASH     = 3'd7
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = 16;
    localparam logic [LED_W-1:0] ON  = '1;
    localparam logic [LED_W-1:0] OFF = '0;

    state_t          state;
    state_t          step_state;
    logic [PW-1:0]   presc;
    logic [CW-1:0]   tcount;
    logic [CW-1:0]   dur;
    logic            btn_q;
    logic            manual_q;
    logic            ped_latch;
    logic            flash_on;
    logic            ret_ns;     // PED_WALK returns to NS_GREEN when set, else EW_GREEN

    logic            tick;
    logic            expire;
    logic            is_manual;
    logic            btn_edge;
    logic            mode_chg;
    logic            advance;

    assign ped_pending = ped_latch;

    always_comb begin
        is_manual = (mode == 2'b01);
        btn_edge  = btn & ~btn_q;
        mode_chg  = (is_manual != manual_q);
        tick      = (presc == PW'(TICK_DIV - 1));

        dur = CW'(1);
        case (state)
            NS_GREEN, EW_GREEN:   dur = CW'(GREEN_SEC);
            NS_YELLOW, EW_YELLOW: dur = CW'(YELLOW_SEC);
            ALL_RED_A, ALL_RED_B: dur = CW'(ALLRED_SEC);
            PED_WALK:             dur = CW'(PED_SEC);
            default:              dur = CW'(1);
        endcase
        expire = tick && (tcount == dur - CW'(1));

        step_state = ALL_RED_B;
        case (state)
            NS_GREEN:  step_state = NS_YELLOW;
            NS_YELLOW: step_state = ALL_RED_A;
            ALL_RED_A: step_state = ped_latch ? PED_WALK : EW_GREEN;
            EW_GREEN:  step_state = EW_YELLOW;
            EW_YELLOW: step_state = ALL_RED_B;
            ALL_RED_B: step_state = ped_latch ? PED_WALK : NS_GREEN;
            PED_WALK:  step_state = ret_ns ? NS_GREEN : EW_GREEN;
            default:   step_state = ALL_RED_B;
        endcase

        // A mode change or flash request swallows any btn edge / expiry in the same cycle.
        advance = !mode[1] && (state != FLASH) && !mode_chg &&
                  (is_manual ? btn_edge : expire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ALL_RED_B;
            presc     <= '0;
            tcount    <= '0;
            btn_q     <= 1'b0;
            manual_q  <= 1'b0;
            ped_latch <= 1'b0;
            flash_on  <= 1'b0;
            ret_ns    <= 1'b0;
            ns_r      <= ON;
            ns_g      <= OFF;
            ns_b      <= OFF;
            ew_r      <= ON;
            ew_g      <= OFF;
            ew_b      <= OFF;
            ped_walk  <= 1'b0;
            phase     <= ALL_RED_B;
        end else begin
            btn_q    <= btn;
            manual_q <= is_manual;

            if (mode[1]) begin
                if (state != FLASH) begin
                    state    <= FLASH;
                    flash_on <= 1'b1;
                    presc    <= '0;
                    tcount   <= '0;
                end else if (tick) begin
                    presc    <= '0;
                    flash_on <= ~flash_on;
                end else begin
                    presc <= presc + PW'(1);
                end
            end else if (state == FLASH) begin
                // Always pass through clearance before any green after night mode.
                state  <= ALL_RED_B;
                presc  <= '0;
                tcount <= '0;
            end else if (mode_chg) begin
                presc  <= '0;
                tcount <= '0;
            end else if (advance) begin
                state  <= step_state;
                presc  <= '0;
                tcount <= '0;
                if (step_state == PED_WALK)
                    ret_ns <= (state == ALL_RED_B);
            end else if (!is_manual) begin
                if (tick) begin
                    presc  <= '0;
                    tcount <= tcount + CW'(1);
                end else begin
                    presc <= presc + PW'(1);
                end
            end

            // Entry into PED_WALK serves the request even if ped_req is high that cycle.
            if (advance && step_state == PED_WALK)
                ped_latch <= 1'b0;
            else if (ped_req && state != PED_WALK && state != FLASH)
                ped_latch <= 1'b1;

            phase    <= state;
            ped_walk <= (state == PED_WALK);
            ns_b     <= OFF;
            ew_b     <= OFF;
            case (state)
                NS_GREEN: begin
                    ns_r <= OFF; ns_g <= ON;  ew_r <= ON;  ew_g <= OFF;
                end
                NS_YELLOW: begin
                    ns_r <= ON;  ns_g <= ON;  ew_r <= ON;  ew_g <= OFF;
                end
                EW_GREEN: begin
                    ns_r <= ON;  ns_g <= OFF; ew_r <= OFF; ew_g <= ON;
                end
                EW_YELLOW: begin
                    ns_r <= ON;  ns_g <= OFF; ew_r <= ON;  ew_g <= ON;
                end
                FLASH: begin
                    ns_r <= flash_on ? ON : OFF;
                    ns_g <= flash_on ? ON : OFF;
                    ew_r <= flash_on ? ON : OFF;
                    ew_g <= flash_on ? ON : OFF;
                end
                default: begin
                    ns_r <= ON;  ns_g <= OFF; ew_r <= ON;  ew_g <= OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_light_intersection.sv
// tb/tb_traffic_light_intersection.sv - self-checking bench for traffic_light_intersection
module tb_traffic_light_intersection;

    localparam int TD = 10;
    localparam logic [3:0] F = 4'hF;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic       btn;
    logic       ped_req;
    logic [3:0] ns_r, ns_g, ns_b, ew_r, ew_g, ew_b;
    logic       ped_walk, ped_pending;
    logic [2:0] phase;

    int checks   = 0;
    int failures = 0;

    traffic_light_intersection #(
        .TICK_DIV(TD), .GREEN_SEC(5), .YELLOW_SEC(2), .ALLRED_SEC(1),
        .PED_SEC(4), .LED_W(4)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .btn(btn), .ped_req(ped_req),
        .ns_r(ns_r), .ns_g(ns_g), .ns_b(ns_b),
        .ew_r(ew_r), .ew_g(ew_g), .ew_b(ew_b),
        .ped_walk(ped_walk), .ped_pending(ped_pending), .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks elapsed cycles in the current phase; a phase ends once it has
    // been occupied for duration*TD cycles. Lamps lag the phase by one clock.
    int   m_st, m_el;
    bit   m_latch, m_ret, m_btnq, m_manq, m_valid;
    logic [2:0]  e_phase;
    logic [23:0] e_lamps;   // {ns_r,ns_g,ns_b,ew_r,ew_g,ew_b}
    logic        e_walk;

    initial m_valid = 0;

    function automatic int dur_of(input int st);
        case (st)
            0, 3:    return 5;
            1, 4:    return 2;
            6:       return 4;
            default: return 1;
        endcase
    endfunction

    // colour code: 0 red, 1 green, 2 yellow, 3 off -> {r,g,b}
    function automatic logic [11:0] col(input int c);
        case (c)
            0:       return {F, 4'h0, 4'h0};
            1:       return {4'h0, F, 4'h0};
            2:       return {F, F, 4'h0};
            default: return 12'h0;
        endcase
    endfunction

    function automatic logic [23:0] lamps_of(input int st, input int el);
        int nc, ec;
        nc = 0; ec = 0;
        if (st == 0) nc = 1;
        if (st == 1) nc = 2;
        if (st == 3) ec = 1;
        if (st == 4) ec = 2;
        if (st == 7) begin
            nc = ((el / TD) % 2 == 0) ? 2 : 3;
            ec = nc;
        end
        return {col(nc), col(ec)};
    endfunction

    always @(posedge clk) begin
        int  old;
        bit  edge_b, man, chg, go;
        if (rst) begin
            m_st = 5; m_el = 0; m_latch = 0; m_ret = 0; m_btnq = 0; m_manq = 0;
            e_phase = 3'd5; e_lamps = lamps_of(5, 0); e_walk = 0;
            m_valid = 1;
        end else begin
            e_phase = 3'(m_st);
            e_lamps = lamps_of(m_st, m_el);
            e_walk  = (m_st == 6);
            old     = m_st;
            edge_b  = btn && !m_btnq;
            m_btnq  = btn;
            man     = (mode == 2'b01);
            chg     = (man != m_manq);
            m_manq  = man;
            go      = 0;
            if (mode[1]) begin
                if (m_st != 7) begin m_st = 7; m_el = 0; end
                else m_el++;
            end else if (m_st == 7) begin
                m_st = 5; m_el = 0;
            end else if (chg) begin
                m_el = 0;
            end else if (man) begin
                go = edge_b;
            end else begin
                m_el++;
                go = (m_el == dur_of(m_st) * TD);
            end
            if (go) begin
                m_el = 0;
                case (old)
                    2:       begin m_st = m_latch ? 6 : 3; m_ret = 0; end
                    5:       begin m_st = m_latch ? 6 : 0; m_ret = 1; end
                    6:       m_st = m_ret ? 0 : 3;
                    default: m_st = old + 1;
                endcase
            end
            if (m_st == 6 && old != 6) m_latch = 0;
            else if (ped_req && old != 6 && old != 7) m_latch = 1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_phase", 32'(phase), 32'(e_phase));
            chk("model_lamps", 32'({ns_r, ns_g, ns_b, ew_r, ew_g, ew_b}), 32'(e_lamps));
            chk("model_ped", 32'({ped_walk, ped_pending}), 32'({e_walk, m_latch}));
        end
    end

    // ---------------- literal expectations ----------------
    task automatic lit_run(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("lit_phase", 32'(phase), 32'(p));
            chk("lit_model", 32'(e_phase), 32'(p));
            chk("lit_walk", 32'(ped_walk), (p == 6) ? 32'd1 : 32'd0);
            chk("lit_ns_g", 32'(ns_g), (p == 0 || p == 1) ? 32'hF : 32'h0);
            chk("lit_ns_r", 32'(ns_r), (p == 0) ? 32'h0 : 32'hF);
            chk("lit_ew_g", 32'(ew_g), (p == 3 || p == 4) ? 32'hF : 32'h0);
            chk("lit_ew_r", 32'(ew_r), (p == 3) ? 32'h0 : 32'hF);
        end
    endtask

    task automatic flash_run(input bit on, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("flash_phase", 32'(phase), 32'd7);
            chk("flash_ns", 32'({ns_r, ns_g, ns_b}), on ? 32'hFF0 : 32'h0);
            chk("flash_ew", 32'({ew_r, ew_g, ew_b}), on ? 32'hFF0 : 32'h0);
        end
    endtask

    initial begin
        rst = 1; mode = 2'b00; btn = 0; ped_req = 0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_phase", 32'(phase), 32'd5);
        chk("reset_lamps", 32'({ns_r, ns_g, ew_r, ew_g}), 32'hF0F0);
        chk("reset_ped", 32'({ped_walk, ped_pending}), 32'd0);
        rst = 0;

        // full auto cycle
        lit_run(5, 10); lit_run(0, 50); lit_run(1, 20); lit_run(2, 10);
        lit_run(3, 50); lit_run(4, 20); lit_run(5, 10);

        // pedestrian pulse during NS_GREEN
        lit_run(0, 5);
        ped_req = 1;
        lit_run(0, 1);
        ped_req = 0;
        chk("ped_latched", 32'(ped_pending), 32'd1);
        lit_run(0, 44); lit_run(1, 20); lit_run(2, 10);
        lit_run(6, 1);
        chk("ped_served", 32'(ped_pending), 32'd0);
        lit_run(6, 39); lit_run(3, 1);

        // manual mode: timer frozen, one step per rising edge, held btn no repeat
        mode = 2'b01;
        lit_run(3, 60);
        btn = 1; lit_run(3, 1); btn = 0; lit_run(4, 19);
        btn = 1; lit_run(4, 1); btn = 0; lit_run(5, 19);
        btn = 1; lit_run(5, 1); lit_run(0, 14); btn = 0; lit_run(0, 5);
        btn = 1; lit_run(0, 1); btn = 0; lit_run(1, 2);
        btn = 1; lit_run(1, 1); btn = 0; lit_run(2, 2);
        btn = 1; lit_run(2, 1); btn = 0; lit_run(3, 3);

        // flash from EW_GREEN, then back to auto via clearance
        mode = 2'b10;
        lit_run(3, 1);
        flash_run(1, 10); flash_run(0, 10); flash_run(1, 10);
        mode = 2'b00;
        flash_run(0, 1);
        lit_run(5, 10); lit_run(0, 3);

        // btn edge together with manual->flash: flash wins, no step
        mode = 2'b01;
        lit_run(0, 3);
        btn = 1; mode = 2'b10;
        lit_run(0, 1);
        flash_run(1, 2);
        btn = 0; mode = 2'b00;
        flash_run(1, 1);
        ped_req = 1; lit_run(5, 1); ped_req = 0; lit_run(5, 9);
        lit_run(6, 5);
        rst = 1;
        lit_run(5, 1);
        chk("rst_mid_walk_pending", 32'(ped_pending), 32'd0);
        rst = 0;
        lit_run(5, 10); lit_run(0, 2);

        // ped_req held through PED_WALK
        ped_req = 1;
        lit_run(0, 48); lit_run(1, 20); lit_run(2, 10);
        for (int i = 0; i < 40; i++) begin
            lit_run(6, 1);
            chk("hold_latch_clear", 32'(ped_pending), 32'd0);
        end
        lit_run(3, 1);
        chk("hold_latch_reset", 32'(ped_pending), 32'd1);
        ped_req = 0;
        lit_run(3, 49); lit_run(4, 20); lit_run(5, 10);
        lit_run(6, 40); lit_run(0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
